mem_wb_stage: RTL and testbench

- Consumer end of the EX/MEM pipeline register.
- Takes the registered EX/MEM control and data, runs the data-memory access over a req/ack handshake, and stalls the front of the pipe while memory is busy.
- Latches the MEM/WB pipeline register that drives register-file write-back and MEM-stage forwarding.
- Sits between the EX/MEM register and the register file / forwarding unit.

---
 rtl/mem_wb_stage_pkg.sv | 21 ++
 rtl/mem_wb_stage_if.sv | 33 +++
 rtl/mem_wb_reg.sv | 55 +++++
 rtl/mem_wb_stage.sv | 114 +++++++++++
 tb/tb_mem_wb_stage.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Shared pipeline definitions for the MEM/WB stage: FSM encoding, default widths and the
// MEM/WB control bundle.
package mem_wb_stage_pkg;

   localparam int unsigned DefDataW = 16;
   localparam int unsigned DefRegW  = 4;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StBusy   = 2'd1,
      StErr    = 2'd2,
      StHalted = 2'd3
   } state_e;

   // Field order is shared with the decode stage; do not reorder.
   typedef struct packed {
      logic reg_write;
      logic halt;
   } wb_ctrl_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-memory request/ack bus between the MEM stage (master) and the memory (slave).
interface mem_wb_stage_if
   import mem_wb_stage_pkg::*;
#(
   parameter int unsigned DATA_W = DefDataW
) ();

   logic              mem_req;
   logic              mem_we;
   logic [DATA_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_wdata,
      input  mem_ack,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      output mem_ack,
      output mem_rdata
   );

endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: loads a completed slot, otherwise inserts a bubble while
// holding the last destination and data.
module mem_wb_reg
   import mem_wb_stage_pkg::*;
#(
   parameter int unsigned DataW = DefDataW,
   parameter int unsigned RegW  = DefRegW
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  wb_ctrl_t         ctrl_i,
   input  logic [RegW-1:0]  dst_i,
   input  logic [DataW-1:0] data_i,
   output logic             valid_o,
   output logic             reg_write_o,
   output logic [RegW-1:0]  dst_o,
   output logic [DataW-1:0] data_o,
   output logic             halt_o
);

   logic             valid_q, reg_write_q, halt_q;
   logic [RegW-1:0]  dst_q;
   logic [DataW-1:0] data_q;

   // Valid and write-enable drop to zero on a bubble; payload only loads with the slot.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q     <= 1'b0;
         reg_write_q <= 1'b0;
      end else begin
         valid_q     <= load_i;
         reg_write_q <= load_i & ctrl_i.reg_write;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         dst_q  <= '0;
         data_q <= '0;
         halt_q <= 1'b0;
      end else if (load_i) begin
         dst_q  <= dst_i;
         data_q <= data_i;
         halt_q <= halt_q | ctrl_i.halt;
      end
   end

   assign valid_o     = valid_q;
   assign reg_write_o = reg_write_q;
   assign dst_o       = dst_q;
   assign data_o      = data_q;
   assign halt_o      = halt_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage: drives the data-memory handshake from the EX/MEM register, stalls the front of
// the pipe while memory is busy, and feeds the MEM/WB register.
module mem_wb_stage
   import mem_wb_stage_pkg::*;
#(
   parameter int unsigned DATA_W  = DefDataW,
   parameter int unsigned REG_W   = DefRegW,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic              flush,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic              MemtoReg,
   input  logic              RegWrite,
   input  logic              Halt,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [DATA_W-1:0] store_data,
   input  logic [REG_W-1:0]  DstReg_in,
   mem_wb_stage_if.master    mem,
   output logic              stall,
   output logic              wb_valid,
   output logic              wb_RegWrite,
   output logic [REG_W-1:0]  wb_DstReg,
   output logic [DATA_W-1:0] wb_data,
   output logic              wb_halt,
   output logic              mem_err
);

   localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   state_e          state_q, state_d;
   logic [CntW-1:0] wait_cnt_q, wait_cnt_d, wait_inc;
   logic            live, op, complete;
   wb_ctrl_t        ctrl;

   // Flush cannot abort an in-flight access, so it is ignored once the FSM is waiting.
   assign live     = in_valid & ~(flush & (state_q != StBusy)) & (state_q != StHalted);
   assign op       = live & (MemRead | MemWrite);
   assign complete = live & (~op | (mem.mem_req & mem.mem_ack));
   assign wait_inc = wait_cnt_q + CntW'(1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // wait_cnt holds the number of wait cycles already spent, including the IDLE one.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = '0;
      unique case (state_q)
         StIdle: begin
            if (mem.mem_req & ~mem.mem_ack) begin
               state_d    = StBusy;
               wait_cnt_d = CntW'(1);
            end else if (complete & Halt) begin
               state_d = StHalted;
            end
         end
         StBusy: begin
            if (!mem.mem_req) begin
               state_d = StIdle;
            end else if (mem.mem_ack) begin
               state_d = Halt ? StHalted : StIdle;
            end else if (wait_inc >= CntW'(TIMEOUT)) begin
               state_d = StErr;
            end else begin
               wait_cnt_d = wait_inc;
            end
         end
         default: begin
            state_d = state_q;
         end
      endcase
   end

   // Gating with rst makes the request drop the instant reset asserts.
   always_comb begin
      mem_err       = (state_q == StErr);
      mem.mem_req   = op & ~mem_err & rst;
      mem.mem_we    = MemWrite;
      mem.mem_addr  = alu_result;
      mem.mem_wdata = store_data;
      stall         = mem.mem_req & ~mem.mem_ack;
   end

   assign ctrl = '{reg_write: RegWrite, halt: Halt};

   mem_wb_reg #(
      .DataW (DATA_W),
      .RegW  (REG_W)
   ) u_mem_wb_reg (
      .clk_i       (clk),
      .rst_ni      (rst),
      .load_i      (complete),
      .ctrl_i      (ctrl),
      .dst_i       (DstReg_in),
      .data_i      (MemtoReg ? mem.mem_rdata : alu_result),
      .valid_o     (wb_valid),
      .reg_write_o (wb_RegWrite),
      .dst_o       (wb_DstReg),
      .data_o      (wb_data),
      .halt_o      (wb_halt)
   );

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: ALU pass-through, zero-wait and multi-wait accesses,
// timeout, halt and asynchronous reset mid-request.
module tb_mem_wb_stage;

   logic        clk, rst;
   logic        in_valid, flush, MemRead, MemWrite, MemtoReg, RegWrite, Halt;
   logic [15:0] alu_result, store_data;
   logic [3:0]  DstReg_in;
   logic        stall, wb_valid, wb_RegWrite, wb_halt, mem_err;
   logic [3:0]  wb_DstReg;
   logic [15:0] wb_data;
   int          n_tests = 0;
   int          n_fail  = 0;

   mem_wb_stage_if mem_bus ();

   mem_wb_stage dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .flush       (flush),
      .MemRead     (MemRead),
      .MemWrite    (MemWrite),
      .MemtoReg    (MemtoReg),
      .RegWrite    (RegWrite),
      .Halt        (Halt),
      .alu_result  (alu_result),
      .store_data  (store_data),
      .DstReg_in   (DstReg_in),
      .mem         (mem_bus),
      .stall       (stall),
      .wb_valid    (wb_valid),
      .wb_RegWrite (wb_RegWrite),
      .wb_DstReg   (wb_DstReg),
      .wb_data     (wb_data),
      .wb_halt     (wb_halt),
      .mem_err     (mem_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic clear_inputs();
      in_valid = 0; flush = 0; MemRead = 0; MemWrite = 0; MemtoReg = 0;
      RegWrite = 0; Halt = 0; alu_result = '0; store_data = '0; DstReg_in = '0;
      mem_bus.mem_ack = 0; mem_bus.mem_rdata = '0;
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 0;
      @(negedge clk);
      rst = 1;
      next_cyc();
   endtask

   initial begin
      rst = 0;
      clear_inputs();
      #12;
      check_eq("rst_wb_valid", wb_valid, 0);
      check_eq("rst_wb_data", wb_data, 0);
      check_eq("rst_wb_halt", wb_halt, 0);
      check_eq("rst_mem_err", mem_err, 0);
      check_eq("rst_mem_req", mem_bus.mem_req, 0);
      @(negedge clk);
      rst = 1;
      next_cyc();

      // ALU-only op
      in_valid = 1; RegWrite = 1; DstReg_in = 4'h3; alu_result = 16'h1234;
      @(negedge clk);
      check_eq("alu_stall", stall, 0);
      check_eq("alu_mem_req", mem_bus.mem_req, 0);
      next_cyc();
      clear_inputs();
      check_eq("alu_wb_valid", wb_valid, 1);
      check_eq("alu_wb_regwrite", wb_RegWrite, 1);
      check_eq("alu_wb_dst", wb_DstReg, 4'h3);
      check_eq("alu_wb_data", wb_data, 16'h1234);
      next_cyc();
      check_eq("bubble_wb_valid", wb_valid, 0);
      check_eq("bubble_wb_data_hold", wb_data, 16'h1234);

      // Zero-wait load
      in_valid = 1; MemRead = 1; MemtoReg = 1; RegWrite = 1; DstReg_in = 4'h5;
      alu_result = 16'h0040; mem_bus.mem_ack = 1; mem_bus.mem_rdata = 16'hBEEF;
      @(negedge clk);
      check_eq("ld0_mem_req", mem_bus.mem_req, 1);
      check_eq("ld0_stall", stall, 0);
      check_eq("ld0_mem_we", mem_bus.mem_we, 0);
      check_eq("ld0_mem_addr", mem_bus.mem_addr, 16'h0040);
      next_cyc();
      clear_inputs();
      check_eq("ld0_wb_valid", wb_valid, 1);
      check_eq("ld0_wb_dst", wb_DstReg, 4'h5);
      check_eq("ld0_wb_data", wb_data, 16'hBEEF);

      // Read and write together is a write
      in_valid = 1; MemRead = 1; MemWrite = 1; alu_result = 16'h0022;
      mem_bus.mem_ack = 1; mem_bus.mem_rdata = 16'h7777;
      @(negedge clk);
      check_eq("rw_mem_we", mem_bus.mem_we, 1);
      next_cyc();
      clear_inputs();
      check_eq("rw_wb_data", wb_data, 16'h0022);

      // Store acked on the 4th cycle; flush during a wait cycle must be ignored
      in_valid = 1; MemWrite = 1; alu_result = 16'h0010; store_data = 16'h00AA;
      for (int i = 0; i < 4; i++) begin
         if (i == 1) flush = 1;
         if (i == 2) flush = 0;
         if (i == 3) mem_bus.mem_ack = 1;
         @(negedge clk);
         check_eq($sformatf("st_mem_req_%0d", i), mem_bus.mem_req, 1);
         check_eq($sformatf("st_mem_we_%0d", i), mem_bus.mem_we, 1);
         check_eq($sformatf("st_mem_addr_%0d", i), mem_bus.mem_addr, 16'h0010);
         check_eq($sformatf("st_mem_wdata_%0d", i), mem_bus.mem_wdata, 16'h00AA);
         check_eq($sformatf("st_stall_%0d", i), stall, (i < 3) ? 1 : 0);
         next_cyc();
         if (i < 3) begin
            check_eq($sformatf("st_wb_valid_%0d", i), wb_valid, 0);
         end else begin
            clear_inputs();
            check_eq("st_wb_valid_done", wb_valid, 1);
            check_eq("st_wb_regwrite", wb_RegWrite, 0);
         end
      end

      // Timeout: no ack ever
      in_valid = 1; MemRead = 1; MemtoReg = 1; RegWrite = 1; alu_result = 16'h0080;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         check_eq($sformatf("to_stall_%0d", i), stall, 1);
         check_eq($sformatf("to_mem_err_%0d", i), mem_err, 0);
         next_cyc();
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq($sformatf("to_err_%0d", i), mem_err, 1);
         check_eq($sformatf("to_req_blocked_%0d", i), mem_bus.mem_req, 0);
         check_eq($sformatf("to_stall_off_%0d", i), stall, 0);
         next_cyc();
         check_eq($sformatf("to_wb_valid_%0d", i), wb_valid, 0);
      end
      clear_inputs();
      do_reset();
      check_eq("to_err_cleared", mem_err, 0);

      // Halt
      in_valid = 1; Halt = 1;
      next_cyc();
      clear_inputs();
      check_eq("halt_wb_halt", wb_halt, 1);
      check_eq("halt_wb_valid", wb_valid, 1);
      in_valid = 1; MemRead = 1; MemtoReg = 1; RegWrite = 1; alu_result = 16'h0044;
      mem_bus.mem_ack = 1; mem_bus.mem_rdata = 16'h1111;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq($sformatf("halted_mem_req_%0d", i), mem_bus.mem_req, 0);
         check_eq($sformatf("halted_stall_%0d", i), stall, 0);
         next_cyc();
         check_eq($sformatf("halted_wb_valid_%0d", i), wb_valid, 0);
         check_eq($sformatf("halted_sticky_%0d", i), wb_halt, 1);
      end
      clear_inputs();
      do_reset();
      check_eq("halt_cleared", wb_halt, 0);

      // Reset in the 2nd wait cycle, after an ALU op has loaded the MEM/WB register
      in_valid = 1; RegWrite = 1; DstReg_in = 4'h7; alu_result = 16'h5A5A;
      next_cyc();
      check_eq("pre_wb_data", wb_data, 16'h5A5A);
      in_valid = 1; MemRead = 1; MemtoReg = 1; RegWrite = 1; DstReg_in = 4'h9;
      alu_result = 16'h0050; mem_bus.mem_ack = 0;
      next_cyc();
      check_eq("pre_rst_stall", stall, 1);
      #2;
      rst = 0;
      #1;
      check_eq("arst_mem_req", mem_bus.mem_req, 0);
      check_eq("arst_stall", stall, 0);
      check_eq("arst_wb_valid", wb_valid, 0);
      check_eq("arst_wb_regwrite", wb_RegWrite, 0);
      check_eq("arst_wb_dst", wb_DstReg, 0);
      check_eq("arst_wb_data", wb_data, 0);
      check_eq("arst_wb_halt", wb_halt, 0);
      @(negedge clk);
      rst = 1;
      next_cyc();
      mem_bus.mem_ack = 1; mem_bus.mem_rdata = 16'hC0DE;
      @(negedge clk);
      check_eq("post_rst_mem_req", mem_bus.mem_req, 1);
      check_eq("post_rst_stall", stall, 0);
      next_cyc();
      clear_inputs();
      check_eq("post_rst_wb_valid", wb_valid, 1);
      check_eq("post_rst_wb_dst", wb_DstReg, 4'h9);
      check_eq("post_rst_wb_data", wb_data, 16'hC0DE);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
